// File: rtl/binary_to_gray.sv
// binary_to_gray: registered binary -> reflected Gray converter.
// Optional self-checker enabled by BINARY_TO_GRAY_CHECK_EN.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   async active-low reset
//   binary    in   [WIDTH-1:0] word to convert
//   in_valid  in   convert binary this cycle
//   gray      out  [WIDTH-1:0] registered Gray code
//   out_valid out  one pulse per accepted word
//   check_err out  sticky decode mismatch flag
//                  (only with BINARY_TO_GRAY_CHECK_EN)
module binary_to_gray #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] binary,
  input  logic             in_valid,
  output logic [WIDTH-1:0] gray,
`ifdef BINARY_TO_GRAY_CHECK_EN
  output logic             out_valid,
  output logic             check_err
`else
  output logic             out_valid
`endif
);

  logic [WIDTH-1:0] gray_d;

  assign gray_d = binary ^ (binary >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid)
        gray <= gray_d;
    end
  end

`ifdef BINARY_TO_GRAY_CHECK_EN
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] dec;

  // Copy of the accepted word, aligned with gray.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bin_q <= '0;
    else if (in_valid)
      bin_q <= binary;
  end

  // Inverse: prefix XOR from the MSB down.
  always_comb begin
    dec = '0;
    dec[WIDTH-1] = gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--)
      dec[i] = dec[i+1] ^ gray[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      check_err <= 1'b0;
    else if (out_valid && (dec != bin_q))
      check_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_binary_to_gray.sv
// tb_binary_to_gray: directed checks for binary_to_gray.
// Covers WIDTH=4 sweep, hold, wrap, resets and WIDTH=8.
module tb_binary_to_gray;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] b4 = '0;
  logic       v4 = 1'b0;
  logic [3:0] g4;
  logic       ov4;
  logic [7:0] b8 = '0;
  logic       v8 = 1'b0;
  logic [7:0] g8;
  logic       ov8;
`ifdef BINARY_TO_GRAY_CHECK_EN
  logic       ce4;
  logic       ce8;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  binary_to_gray #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .binary    (b4),
    .in_valid  (v4),
    .gray      (g4),
`ifdef BINARY_TO_GRAY_CHECK_EN
    .out_valid (ov4),
    .check_err (ce4)
`else
    .out_valid (ov4)
`endif
  );

  binary_to_gray #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .binary    (b8),
    .in_valid  (v8),
    .gray      (g8),
`ifdef BINARY_TO_GRAY_CHECK_EN
    .out_valid (ov8),
    .check_err (ce8)
`else
    .out_valid (ov8)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] tbl [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110,
    4'b1010, 4'b1011, 4'b1001, 4'b1000
  };

  logic [3:0] prev;

  initial begin
    #3;
    chk("rst_gray4", 32'(g4), 32'h0);
    chk("rst_ov4", 32'(ov4), 32'h0);
    chk("rst_gray8", 32'(g8), 32'h0);
    chk("rst_ov8", 32'(ov8), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_ov4", 32'(ov4), 32'h0);

    // exhaustive sweep, back-to-back
    for (int i = 0; i < 16; i++) begin
      b4 = 4'(i);
      v4 = 1'b1;
      tick();
      chk($sformatf("sweep_g%0d", i),
          32'(g4), 32'(tbl[i]));
      chk($sformatf("sweep_v%0d", i),
          32'(ov4), 32'h1);
    end
    v4 = 1'b0;
    tick();
    chk("post_sweep_ov", 32'(ov4), 32'h0);
    chk("post_sweep_g", 32'(g4), 32'h8);

    // hold with in_valid low
    b4 = 4'b0110;
    v4 = 1'b1;
    tick();
    chk("hold_load", 32'(g4), 32'h5);
    b4 = 4'b1111;
    v4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold_g%0d", i), 32'(g4), 32'h5);
      chk($sformatf("hold_v%0d", i), 32'(ov4), 32'h0);
    end
    b4 = 4'bxxxx;
    tick();
    chk("hold_x", 32'(g4), 32'h5);

    // wrap 1111 -> 0000
    b4 = 4'b1111;
    v4 = 1'b1;
    tick();
    chk("wrap_hi", 32'(g4), 32'h8);
    prev = g4;
    b4 = 4'b0000;
    tick();
    chk("wrap_lo", 32'(g4), 32'h0);
    chk("wrap_ham", 32'($countones(prev ^ g4)), 32'h1);
    chk("wrap_ov", 32'(ov4), 32'h1);

    // width 8
    b8 = 8'hFF;
    v8 = 1'b1;
    tick();
    chk("w8_ff", 32'(g8), 32'h80);
    chk("w8_ov", 32'(ov8), 32'h1);
    b8 = 8'hA5;
    tick();
    chk("w8_a5", 32'(g8), 32'hF7);
    b8 = 8'h00;
    tick();
    chk("w8_00", 32'(g8), 32'h00);
    v8 = 1'b0;

    // async reset between edges
    b4 = 4'b1101;
    v4 = 1'b1;
    tick();
    chk("pre_rst_g", 32'(g4), 32'hB);
    v4 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_g", 32'(g4), 32'h0);
    chk("arst_ov", 32'(ov4), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // reset mid-stream
    b4 = 4'b1010;
    v4 = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_g", 32'(g4), 32'h0);
    v4 = 1'b0;
    tick();
    chk("mid_in_rst_ov", 32'(ov4), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mid_rel_ov", 32'(ov4), 32'h0);
    chk("mid_rel_g", 32'(g4), 32'h0);
    b4 = 4'b0011;
    v4 = 1'b1;
    tick();
    chk("mid_first_g", 32'(g4), 32'h2);
    chk("mid_first_ov", 32'(ov4), 32'h1);
    v4 = 1'b0;
    tick();
    chk("mid_after_ov", 32'(ov4), 32'h0);

`ifdef BINARY_TO_GRAY_CHECK_EN
    chk("check_err4", 32'(ce4), 32'h0);
    chk("check_err8", 32'(ce8), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
